// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: datapath width, the NOP encoding and the
// fetch-stage state type.
package simplerisc_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;

    // opcode 01101 with all operand fields zero
    localparam logic [XLEN-1:0] NOP_INST = 32'h6800_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [XLEN-1:0] inst);
        return inst[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid register parking a fetched word (and its PC) while the
// downstream latch is stalled.
module fetch_hold_buf
    import simplerisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            flush,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    output logic            hold_valid,
    output logic [XLEN-1:0] hold_inst,
    output logic [XLEN-1:0] hold_pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // flush (branch) wins over a same-cycle load
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign hold_valid = valid_q;
    assign hold_inst  = inst_q;
    assign hold_pc    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// SimpleRISC instruction-fetch stage: owns the PC, runs the imem req/ack
// handshake and drives the IF/OF latch inputs, honouring stall and redirect.
module if_fetch_unit
    import simplerisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_IF,
    output logic [31:0] pc_IF,
    output logic        valid_IF
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic            squash_q, squash_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pcif_q, pcif_d;
    logic            valid_q, valid_d;

    logic            hb_load, hb_unload, hb_flush;
    logic            hold_valid;
    logic [XLEN-1:0] hold_inst, hold_pc;

    fetch_hold_buf u_hold (
        .clk        (clk),
        .rst        (reset),
        .load       (hb_load),
        .unload     (hb_unload),
        .flush      (hb_flush),
        .load_inst  (imem_rdata),
        .load_pc    (pc_q),
        .hold_valid (hold_valid),
        .hold_inst  (hold_inst),
        .hold_pc    (hold_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        redir_d   = redir_q;
        squash_d  = squash_q;
        inst_d    = inst_q;
        pcif_d    = pcif_q;
        valid_d   = valid_q;
        hb_load   = 1'b0;
        hb_unload = 1'b0;
        hb_flush  = 1'b0;

        // an unstalled cycle that produces no word presents a bubble
        if (!stop) begin
            inst_d  = NOP_INST;
            pcif_d  = '0;
            valid_d = 1'b0;
        end

        if (branch_taken) begin
            inst_d   = NOP_INST;
            pcif_d   = '0;
            valid_d  = 1'b0;
            hb_flush = 1'b1;
            state_d  = FETCH;
            // An outstanding request must keep its address until acked, so the
            // target waits in redir_q and becomes the PC on the discarded ack.
            if (state_q == FETCH && !imem_ack) begin
                squash_d = 1'b1;
                redir_d  = branch_pc;
            end else begin
                squash_d = 1'b0;
                pc_d     = branch_pc;
            end
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            pc_d     = redir_q;
                        end else if (stop) begin
                            hb_load = 1'b1;
                            pc_d    = pc_q + XLEN'(PC_STEP);
                            state_d = HOLD;
                        end else begin
                            inst_d  = imem_rdata;
                            pcif_d  = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + XLEN'(PC_STEP);
                        end
                    end
                end
                HOLD: begin
                    if (!stop) begin
                        if (hold_valid) begin
                            inst_d  = hold_inst;
                            pcif_d  = hold_pc;
                            valid_d = 1'b1;
                        end
                        hb_unload = 1'b1;
                        state_d   = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            redir_q  <= '0;
            squash_q <= 1'b0;
            inst_q   <= NOP_INST;
            pcif_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            redir_q  <= redir_d;
            squash_q <= squash_d;
            inst_q   <= inst_d;
            pcif_q   <= pcif_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign inst_IF   = inst_q;
    assign pc_IF     = pcif_q;
    assign valid_IF  = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a memory model returning addr^key and an
// in-order program-stream reference for the words consumed downstream.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [31:0] NOP  = 32'h6800_0000;
    localparam logic [31:0] WRAP_START = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop, branch_taken;
    logic [31:0] branch_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] inst_IF, pc_IF;
    logic        valid_IF;

    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_rdata, w_inst, w_pc;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned consumed = 0;

    logic [31:0] exp_pc;
    logic [31:0] w_exp;
    logic        w_wrapped;

    logic        has_prev;
    logic        prev_stop, prev_br, prev_req, prev_ack, prev_valid;
    logic [31:0] prev_addr, prev_inst, prev_pcif;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .stop         (stop),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_IF      (inst_IF),
        .pc_IF        (pc_IF),
        .valid_IF     (valid_IF)
    );

    assign w_ack   = w_req;
    assign w_rdata = w_addr ^ KEY;

    if_fetch_unit #(.RESET_PC(WRAP_START), .PC_STEP(4)) u_wrap (
        .clk          (clk),
        .reset        (reset),
        .stop         (1'b0),
        .branch_taken (1'b0),
        .branch_pc    (32'h0),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_ack     (w_ack),
        .imem_rdata   (w_rdata),
        .inst_IF      (w_inst),
        .pc_IF        (w_pc),
        .valid_IF     (w_valid)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc    = 32'h0;
        w_exp     = WRAP_START;
        has_prev  = 1'b0;
    endtask

    // Check outputs produced by the last edge, drive this cycle's inputs,
    // score the word the downstream latch takes at the coming edge.
    task automatic step(input logic st, input logic br, input logic [31:0] bpc, input logic ack_en);
        if (has_prev) begin
            if (prev_br) begin
                check_val("bubble_valid", 32'(valid_IF), 32'd0);
                check_val("bubble_inst", inst_IF, NOP);
                check_val("bubble_pc", pc_IF, 32'd0);
            end else if (prev_stop) begin
                check_val("stall_inst", inst_IF, prev_inst);
                check_val("stall_pc", pc_IF, prev_pcif);
                check_val("stall_valid", 32'(valid_IF), 32'(prev_valid));
            end
            if (prev_req && !prev_ack) begin
                check_val("wait_req", 32'(imem_req), 32'd1);
                check_val("wait_addr", imem_addr, prev_addr);
            end
        end
        if (w_valid) begin
            check_val("wrap_pc", w_pc, w_exp);
            check_val("wrap_inst", w_inst, w_exp ^ KEY);
            if (w_exp == 32'h0 && w_pc == 32'h0) w_wrapped = 1'b1;
            w_exp = w_exp + 32'd4;
        end

        stop         = st;
        branch_taken = br;
        branch_pc    = bpc;
        imem_ack     = ack_en && imem_req;
        imem_rdata   = imem_ack ? (imem_addr ^ KEY) : $urandom;

        if (valid_IF && !st && !br) begin
            check_val("stream_pc", pc_IF, exp_pc);
            check_val("stream_inst", inst_IF, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (br) exp_pc = bpc;

        prev_stop  = st;
        prev_br    = br;
        prev_req   = imem_req;
        prev_ack   = imem_ack;
        prev_addr  = imem_addr;
        prev_inst  = inst_IF;
        prev_pcif  = pc_IF;
        prev_valid = valid_IF;
        has_prev   = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic last_br;
        logic st, br, ak;
        logic [31:0] bpc;

        reset = 1'b1; stop = 1'b0; branch_taken = 1'b0; branch_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; w_wrapped = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_valid", 32'(valid_IF), 32'd0);
        check_val("rst_inst", inst_IF, NOP);
        check_val("rst_pc_if", pc_IF, 32'd0);
        check_val("rst_addr", imem_addr, 32'd0);
        check_val("rst_wrap_addr", w_addr, WRAP_START);
        reset = 1'b0;

        // straight-line fetch, then stall on the ack for PC 8
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("addr_before_stall", imem_addr, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check_val("hold_req", 32'(imem_req), 32'd0);
        check_val("hold_out_pc", pc_IF, 32'h4);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("unload_pc", pc_IF, 32'h8);
        check_val("unload_valid", 32'(valid_IF), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // redirect while the request for 0x10 is still waiting
        check_val("addr_before_squash", imem_addr, 32'h10);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        check_val("squash_addr", imem_addr, 32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("redirect_addr", imem_addr, 32'h100);
        check_val("squash_valid", 32'(valid_IF), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // redirect while holding a parked word under stall
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        check_val("hold_branch_req", 32'(imem_req), 32'd1);
        check_val("hold_branch_addr", imem_addr, 32'h200);

        last_br = 1'b0;
        for (int i = 0; i < 500; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            br  = !last_br && ($urandom_range(0, 11) == 0);
            ak  = ($urandom_range(0, 2) != 0);
            bpc = $urandom & 32'h0003_FFFC;
            step(st, br, bpc, ak);
            last_br = br;
        end
        check_val("progress", 32'(consumed > 100), 32'd1);
        check_val("wrap_seen", 32'(w_wrapped), 32'd1);

        // asynchronous reset in the middle of an unacknowledged request
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("pre_rst_req", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_req", 32'(imem_req), 32'd0);
        check_val("async_valid", 32'(valid_IF), 32'd0);
        check_val("async_inst", inst_IF, NOP);
        check_val("async_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch (IF) stage of the SimpleRISC 5-stage pipeline.
- Producer side of the IF/OF pipeline register: owns the PC, runs the req/ack handshake to instruction memory, and drives inst_IF/pc_IF/valid_IF into the IF/OF latch.
- Honours the downstream stall (stop) without losing a returned word.
- Redirects on taken branches from EX, inserting NOP bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per fetched instruction, in bytes.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stop  in  1  downstream stall; while high, the IF outputs must not change.
- branch_taken  in  1  single-cycle redirect pulse from EX.
- branch_pc  in  32  redirect target; valid only with branch_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc_reg whenever imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req=0.
- imem_rdata  in  32  fetched instruction word.
- inst_IF  out  32  instruction presented to the IF/OF latch.
- pc_IF  out  32  PC of inst_IF.
- valid_IF  out  1  inst_IF is a real instruction, not a bubble.

Behaviour:
- Reset (async, active-high), all forced immediately:
  - state=IDLE, pc_reg=RESET_PC, imem_req=0.
  - inst_IF=NOP_INST (32'h6800_0000, opcode 01101), pc_IF=0, valid_IF=0.
  - hold_valid=0, squash=0.
- Reset asserted mid-handshake aborts the request. The memory must drop any pending ack.
- States:
  - IDLE: exits to FETCH on the first clk after reset deasserts; imem_req=0.
  - FETCH: imem_req=1, imem_addr=pc_reg. imem_req stays high until imem_ack; the address is stable while waiting.
  - HOLD: imem_req=0; a word is parked in hold_inst/hold_pc.
- FETCH, imem_ack=1, stop=0, no squash:
  - inst_IF<=imem_rdata, pc_IF<=pc_reg, valid_IF<=1.
  - pc_reg<=pc_reg+PC_STEP; stay in FETCH.
  - Back-to-back acks give 1 instruction/cycle. Latency is 1 clk from ack to inst_IF.
- FETCH, imem_ack=1, stop=1: park the word in hold_inst/hold_pc, pc_reg+=PC_STEP, go to HOLD. IF outputs unchanged.
- HOLD, stop=0: outputs<=hold word, valid_IF<=1, go to FETCH. The next request is issued in the following cycle.
- Stop with no ack pending: outputs held; the request continues.
- Branch (branch_taken=1), highest priority, any state:
  - pc_reg<=branch_pc.
  - inst_IF<=NOP_INST, valid_IF<=0, pc_IF<=0, even when stop=1 (flush overrides stall).
  - hold_valid<=0; HOLD goes to FETCH.
  - If FETCH has an unacked request, set squash=1. The request stays up with its old address until ack; that ack's data is discarded, squash clears, and the next request uses branch_pc.
- Branch in the same cycle as ack: data discarded, pc_reg<=branch_pc, no squash needed.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. branch_pc is used as given, with no alignment check.
- No combinational path from any input to imem_req or inst_IF/pc_IF/valid_IF. imem_addr is registered (pc_reg).

Decomposition:
- Shared package simplerisc_pkg: NOP_INST, OPCODE_MSB/LSB (31/27), XLEN=32, fetch state enum (IDLE, FETCH, HOLD).
- One natural sub-module: fetch_hold_buf, a single-entry skid register with hold_valid/hold_inst/hold_pc, load, unload and flush.
- The rest is a flat FSM in if_fetch_unit.

Test Plan:
- Reset release, memory acks every cycle with rdata=addr^32'hA5A5_0000 -> pc_IF=0,4,8,... on consecutive clks, valid_IF=1, inst_IF matches.
- Ack for PC 8 while stop=1 for 3 clks -> outputs frozen at PC 4; imem_req=0 in HOLD; inst for PC 8 appears the clk after stop falls; no word dropped or duplicated.
- branch_taken with branch_pc=0x100 while the request for 0x10 waits 2 clks for ack -> inst_IF=0x6800_0000, valid_IF=0; 0x10 data discarded; next imem_addr=0x100.
- Branch in HOLD with stop=1 -> held word dropped, bubble output, fetch resumes at branch_pc.
- RESET_PC=32'hFFFF_FFF8 with continuous acks -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted asynchronously mid-wait -> imem_req=0 and valid_IF=0 immediately, without waiting for a clk edge.
